// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, square packing and the turn sequencer state type.
package chess_pkg;

   localparam logic [3:0] EMPTY     = 4'd0;
   localparam int         COLOR_BIT = 3;
   localparam logic       WHITE     = 1'b0;
   localparam logic       BLACK     = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StSelSrc,
      StChkSrc,
      StSelDst,
      StChkDst,
      StIssue,
      StSwitch,
      StOver
   } turn_state_t;

   function automatic logic [5:0] sq_addr(input logic [2:0] y, input logic [2:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-player chess clock: one-second tick divider plus a white and a black countdown.
module turn_timer
   import chess_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
   parameter int unsigned START_SECONDS = 600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic       active_side,
   input  logic       restart,
   input  logic       reload,
   output logic [9:0] time_w,
   output logic [9:0] time_b,
   output logic       expired
);

   localparam int unsigned     CntW     = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam logic [CntW-1:0] CntMax   = CntW'(CLK_FREQ_HZ - 1);
   localparam logic [9:0]      StartVal = 10'(START_SECONDS);

   logic [CntW-1:0] cnt_q;
   logic [9:0]      time_w_q, time_b_q, active_time;
   logic            wrap;

   assign wrap        = run && !restart && (cnt_q == CntMax);
   assign active_time = (active_side == BLACK) ? time_b_q : time_w_q;
   // Only the decrement that lands on zero counts; a clock already at zero stays there.
   assign expired     = wrap && (active_time == 10'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         time_w_q <= StartVal;
         time_b_q <= StartVal;
      end else begin
         if (!run || restart || wrap) cnt_q <= '0;
         else                         cnt_q <= cnt_q + CntW'(1);

         if (reload) begin
            time_w_q <= StartVal;
            time_b_q <= StartVal;
         end else if (wrap && (active_time != 10'd0)) begin
            if (active_side == BLACK) time_b_q <= time_b_q - 10'd1;
            else                      time_w_q <= time_w_q - 10'd1;
         end
      end
   end

   assign time_w = time_w_q;
   assign time_b = time_b_q;

endmodule

// File: rtl/turn_controller.sv
// Chess turn sequencer: cursor, source/destination selection, move handshake, turn clocks.
// Define TURN_TIMER_EN to build the per-player countdown and timeout; otherwise clocks read 0.
module turn_controller
   import chess_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
   parameter int unsigned START_SECONDS = 600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       game_active,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_enter,
   input  logic       btn_cancel,
   output logic [5:0] rd_addr,
   input  logic [3:0] rd_data,
   output logic       mv_req,
   output logic [5:0] mv_src,
   output logic [5:0] mv_dst,
   input  logic       mv_ack,
   output logic [2:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic       sel_valid,
   output logic [2:0] sel_x,
   output logic [2:0] sel_y,
   output logic       turn,
   output logic [9:0] time_w,
   output logic [9:0] time_b,
   output logic       game_over,
   output logic       loser
);

   turn_state_t state_q, state_d;
   logic [2:0]  cx_q, cx_d, cy_q, cy_d, sx_q, sx_d, sy_q, sy_d;
   logic [5:0]  src_q, src_d, dst_q, dst_d;
   logic        ga_q, ga_rise, own_piece, move_cursor, reload, expired;
   logic        sv_q, sv_d, turn_q, turn_d, pend_q, pend_d;
   logic        over_q, over_d, loser_q, loser_d;

   assign ga_rise   = game_active && !ga_q;
   assign own_piece = (rd_data != EMPTY) && (rd_data[COLOR_BIT] == turn_q);

   always_comb begin
      state_d     = state_q;
      sv_d        = sv_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      turn_d      = turn_q;
      src_d       = src_q;
      dst_d       = dst_q;
      pend_d      = pend_q;
      over_d      = over_q;
      loser_d     = loser_q;
      reload      = 1'b0;
      move_cursor = 1'b0;
      if (state_q == StIdle) begin
         if (ga_rise) begin
            reload  = 1'b1;
            turn_d  = WHITE;
            over_d  = 1'b0;
            loser_d = 1'b0;
            pend_d  = 1'b0;
            state_d = StSelSrc;
         end
      end else if (state_q == StOver) begin
         if (!game_active) state_d = StIdle;
      end else if (state_q == StIssue) begin
         // The handshake always completes; a timeout seen meanwhile is deferred to the ack.
         if (mv_ack) begin
            pend_d = 1'b0;
            if (pend_q || expired) begin
               state_d = StOver;
               over_d  = 1'b1;
               loser_d = turn_q;
               sv_d    = 1'b0;
            end else begin
               state_d = StSwitch;
            end
         end else if (expired) begin
            pend_d = 1'b1;
         end
      end else if (!game_active) begin
         state_d = StIdle;
         sv_d    = 1'b0;
         if (state_q == StSwitch) turn_d = (turn_q == WHITE) ? BLACK : WHITE;
      end else if (expired) begin
         state_d = StOver;
         over_d  = 1'b1;
         loser_d = turn_q;
         sv_d    = 1'b0;
      end else begin
         unique case (state_q)
            StSelSrc: begin
               if (btn_cancel)     ;
               else if (btn_enter) state_d = StChkSrc;
               else                move_cursor = 1'b1;
            end
            StChkSrc: begin
               if (own_piece) begin
                  sv_d    = 1'b1;
                  sx_d    = cx_q;
                  sy_d    = cy_q;
                  state_d = StSelDst;
               end else begin
                  state_d = StSelSrc;
               end
            end
            StSelDst: begin
               if (btn_cancel) begin
                  sv_d    = 1'b0;
                  state_d = StSelSrc;
               end else if (btn_enter) begin
                  state_d = StChkDst;
               end else begin
                  move_cursor = 1'b1;
               end
            end
            StChkDst: begin
               if (((cx_q == sx_q) && (cy_q == sy_q)) || own_piece) begin
                  state_d = StSelDst;
               end else begin
                  src_d   = sq_addr(sy_q, sx_q);
                  dst_d   = sq_addr(cy_q, cx_q);
                  state_d = StIssue;
               end
            end
            StSwitch: begin
               turn_d  = (turn_q == WHITE) ? BLACK : WHITE;
               sv_d    = 1'b0;
               state_d = StSelSrc;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (move_cursor) begin
         if (btn_up)         cy_d = cy_q + 3'd1;
         else if (btn_down)  cy_d = cy_q - 3'd1;
         else if (btn_left)  cx_d = cx_q - 3'd1;
         else if (btn_right) cx_d = cx_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         ga_q    <= 1'b0;
         cx_q    <= '0;
         cy_q    <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         sv_q    <= 1'b0;
         turn_q  <= WHITE;
         src_q   <= '0;
         dst_q   <= '0;
         pend_q  <= 1'b0;
         over_q  <= 1'b0;
         loser_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ga_q    <= game_active;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         sv_q    <= sv_d;
         turn_q  <= turn_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         pend_q  <= pend_d;
         over_q  <= over_d;
         loser_q <= loser_d;
      end
   end

`ifdef TURN_TIMER_EN
   logic run, restart;

   assign run     = (state_q != StIdle) && (state_q != StOver);
   assign restart = (state_q == StSwitch);

   turn_timer #(
      .CLK_FREQ_HZ   (CLK_FREQ_HZ),
      .START_SECONDS (START_SECONDS)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .active_side (turn_q),
      .restart     (restart),
      .reload      (reload),
      .time_w      (time_w),
      .time_b      (time_b),
      .expired     (expired)
   );

   assign game_over = over_q;
   assign loser     = loser_q;
`else
   logic unused_timer;

   assign unused_timer = ^{CLK_FREQ_HZ[0], START_SECONDS[0], over_q, loser_q, reload};
   assign time_w       = '0;
   assign time_b       = '0;
   assign expired      = 1'b0;
   assign game_over    = 1'b0;
   assign loser        = 1'b0;
`endif

   assign rd_addr   = sq_addr(cy_q, cx_q);
   assign mv_req    = (state_q == StIssue);
   assign mv_src    = src_q;
   assign mv_dst    = dst_q;
   assign cursor_x  = cx_q;
   assign cursor_y  = cy_q;
   assign sel_valid = sv_q;
   assign sel_x     = sx_q;
   assign sel_y     = sy_q;
   assign turn      = turn_q;

endmodule
